// File: rtl/arb_pkg.sv
// Shared definitions for the request arbiter: state encoding, sizes and
// helpers used by req_arbiter and prio_pick.
package arb_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam logic [3:0] CODE_IDLE = 4'b0000;

  // One-hot grant vector for a requester index.
  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational priority picker: scans requests downward starting at
// start_idx, wrapping from 0 back to NREQ-1, and reports the first hit.
module prio_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] start_idx,
  output logic            hit,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] pos;

  // Walk from the farthest position toward start_idx so the position
  // closest to start_idx (highest priority) is assigned last and wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = start_idx - IDXW'(k);
      if (req[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// 8-way arbiter with active-low requests. A single winner is registered and
// keeps the grant until it releases or MAX_HOLD cycles elapse, followed by a
// one-cycle GAP and an IDLE decision cycle before the next grant.
// Optional feature: define ROUND_ROBIN_EN for rotating priority (the last
// winner becomes lowest priority); otherwise index 7 always wins over 6..0.
//
// Handshake: req_n[i] low means "requesting". Once gnt[i] is high the
// requester owns the resource until it drives req_n[i] high again; the grant
// drops on the following edge. No other request can preempt a tenure.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_n,
  output logic [NREQ-1:0] gnt,
  output logic [3:0]      gnt_code,
  output logic            busy,
  output logic            timeout
);

  localparam int              CNTW      = $clog2(MAX_HOLD);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

  arb_state_t      state;
  logic [CNTW-1:0] hold_cnt;
  logic [NREQ-1:0] req;
  logic [IDXW-1:0] start_idx;
  logic            hit;
  logic [IDXW-1:0] win_idx;

  assign req = ~req_n;

`ifdef ROUND_ROBIN_EN
  logic [IDXW-1:0] rr_ptr;
  // Search begins just below the last winner, making it lowest priority.
  assign start_idx = rr_ptr - 1'b1;
`else
  assign start_idx = '1;
`endif

  prio_pick u_pick (
    .req       (req),
    .start_idx (start_idx),
    .hit       (hit),
    .idx       (win_idx)
  );

  // Arbitration FSM with hold counter and registered outputs; the current
  // owner's index is carried in gnt_code[2:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_code <= CODE_IDLE;
      busy     <= 1'b0;
      timeout  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      rr_ptr   <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            state    <= GRANT;
            gnt      <= idx_to_onehot(win_idx);
            gnt_code <= {1'b1, win_idx};
            busy     <= 1'b1;
            hold_cnt <= '0;
`ifdef ROUND_ROBIN_EN
            rr_ptr   <= win_idx;
`endif
          end
        end
        GRANT: begin
          // Release takes precedence over the hold limit: no timeout pulse.
          if (req_n[gnt_code[IDXW-1:0]]) begin
            state    <= GAP;
            gnt      <= '0;
            gnt_code <= CODE_IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= GAP;
            gnt      <= '0;
            gnt_code <= CODE_IDLE;
            timeout  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          gnt      <= '0;
          gnt_code <= CODE_IDLE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Bench for req_arbiter: a cycle-level behavioural model of the arbitration
// rules is compared with the DUT every cycle, with directed scenarios pinned
// by literal expectations followed by randomized request traffic.
module tb_req_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_n;
  logic [7:0] gnt;
  logic [3:0] gnt_code;
  logic       busy;
  logic       timeout;

  int n_vec  = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  req_arbiter #(.MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_n    (req_n),
    .gnt      (gnt),
    .gnt_code (gnt_code),
    .busy     (busy),
    .timeout  (timeout)
  );

  // ---------------- behavioural model ----------------
  // phase: 0 = no tenure, 1 = someone holds the grant, 2 = dead gap cycle
  int         m_phase = 0;
  int         m_owner = 0;
  int         m_held  = 0;   // cycles the current grant has been visible
  int         m_last  = 0;   // last winner (rotating priority reference)
  logic [7:0] m_gnt   = '0;
  logic [3:0] m_code  = '0;
  logic       m_busy  = 1'b0;
  logic       m_to    = 1'b0;
  bit         armed   = 1'b0;

  function automatic int pick(input logic [7:0] rq_n, input int last);
    int i;
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      i = (last - k + 8) % 8;
      if (!rq_n[i]) return i;
    end
`else
    for (int j = 7; j >= 0; j--) begin
      i = j + 0 * last;
      if (!rq_n[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (rst) begin
      m_phase = 0; m_held = 0; m_last = 0;
      m_gnt = '0; m_code = '0; m_busy = 1'b0; m_to = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      m_to = 1'b0;
      case (m_phase)
        0: begin
          w = pick(req_n, m_last);
          if (w >= 0) begin
            m_phase = 1; m_owner = w; m_held = 1; m_last = w;
            m_gnt   = 8'b1 << w;
            m_code  = {1'b1, 3'(w)};
            m_busy  = 1'b1;
          end
        end
        1: begin
          if (req_n[m_owner]) begin
            m_phase = 2; m_gnt = '0; m_code = '0;
          end else if (m_held == MH) begin
            m_phase = 2; m_gnt = '0; m_code = '0; m_to = 1'b1;
          end else begin
            m_held++;
          end
        end
        default: begin
          m_phase = 0; m_busy = 1'b0;
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of DUT against the model
  initial forever begin
    @(negedge clk);
    if (armed) begin
      n_vec++;
      if (gnt !== m_gnt || gnt_code !== m_code || busy !== m_busy || timeout !== m_to) begin
        errors++;
        $display("FAIL model t=%0t: got gnt=%h code=%b busy=%b to=%b, want gnt=%h code=%b busy=%b to=%b",
                 $time, gnt, gnt_code, busy, timeout, m_gnt, m_code, m_busy, m_to);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs seen then reflect the
  // previously driven inputs.
  task automatic drive(input logic r, input logic [7:0] rq);
    @(negedge clk);
    rst   = r;
    req_n = rq;
  endtask

  task automatic expect_out(input string nm, input logic [7:0] g, input logic [3:0] c,
                            input logic b, input logic t);
    n_vec++;
    if (gnt !== g || gnt_code !== c || busy !== b || timeout !== t) begin
      errors++;
      $display("FAIL %s: got gnt=%h code=%b busy=%b to=%b, want gnt=%h code=%b busy=%b to=%b",
               nm, gnt, gnt_code, busy, timeout, g, c, b, t);
    end
  endtask

  logic [7:0] cur;
  logic [7:0] second_gnt;
  logic [3:0] second_code;

  initial begin
    rst   = 1'b1;
    req_n = 8'h00;

    // 1: reset held with all requesting, then first grant to 7
    drive(1, 8'h00); expect_out("rst_a", 8'h00, 4'b0000, 0, 0);
    drive(1, 8'h00); expect_out("rst_b", 8'h00, 4'b0000, 0, 0);
    drive(0, 8'h00); expect_out("rst_c", 8'h00, 4'b0000, 0, 0);
    drive(0, 8'hFF); expect_out("first_grant", 8'h80, 4'b1111, 1, 0);

    // 2: release then next-highest requester
    drive(1, 8'hFF);
    drive(0, 8'b1110_1011);
    drive(0, 8'b1111_1011); expect_out("grant4", 8'h10, 4'b1100, 1, 0);
    drive(0, 8'b1111_1011); expect_out("gap_after_rel", 8'h00, 4'b0000, 1, 0);
    drive(0, 8'b1111_1011); expect_out("idle_after_rel", 8'h00, 4'b0000, 0, 0);
    drive(0, 8'hFF);        expect_out("grant2", 8'h04, 4'b1010, 1, 0);

    // 3: hold limit on requester 3
    drive(1, 8'hFF);
    drive(0, 8'hF7);
    for (int i = 0; i < MH; i++) begin
      drive(0, 8'hF7); expect_out("hold3", 8'h08, 4'b1011, 1, 0);
    end
    drive(0, 8'hF7); expect_out("timeout3", 8'h00, 4'b0000, 1, 1);
    drive(0, 8'hF7); expect_out("dead3", 8'h00, 4'b0000, 0, 0);
    drive(0, 8'hFF); expect_out("regrant3", 8'h08, 4'b1011, 1, 0);

    // 4: everyone requesting; second winner depends on priority mode
`ifdef ROUND_ROBIN_EN
    second_gnt = 8'h40; second_code = 4'b1110;
`else
    second_gnt = 8'h80; second_code = 4'b1111;
`endif
    drive(1, 8'hFF);
    drive(0, 8'h00);
    for (int i = 0; i < MH; i++) begin
      drive(0, 8'h00); expect_out("all_first", 8'h80, 4'b1111, 1, 0);
    end
    drive(0, 8'h00); expect_out("all_timeout", 8'h00, 4'b0000, 1, 1);
    drive(0, 8'h00); expect_out("all_dead", 8'h00, 4'b0000, 0, 0);
    drive(0, 8'h00); expect_out("all_second", second_gnt, second_code, 1, 0);
    repeat (40) drive(0, 8'h00);

    // 5: release on the last allowed cycle -> no timeout
    drive(1, 8'hFF);
    drive(0, 8'hF7);
    for (int i = 0; i < MH - 1; i++) begin
      drive(0, 8'hF7); expect_out("hold5", 8'h08, 4'b1011, 1, 0);
    end
    drive(0, 8'hFF); expect_out("last5", 8'h08, 4'b1011, 1, 0);
    drive(0, 8'hFF); expect_out("rel_at_limit", 8'h00, 4'b0000, 1, 0);

    // 6: reset mid-tenure
    drive(1, 8'hFF);
    drive(0, 8'hDF);
    drive(1, 8'h00); expect_out("grant5", 8'h20, 4'b1101, 1, 0);
    drive(0, 8'h00); expect_out("rst_mid", 8'h00, 4'b0000, 0, 0);
    drive(0, 8'h00); expect_out("after_rst", 8'h80, 4'b1111, 1, 0);

    // Randomized traffic with sticky requests and occasional resets
    cur = 8'hFF;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(5) == 0) cur[b] = ~cur[b];
      if ($urandom_range(199) == 0) cur = 8'h00;
      drive(($urandom_range(149) == 0) ? 1'b1 : 1'b0, cur);
    end
    drive(0, 8'hFF);
    repeat (4) drive(0, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errors);
    $finish;
  end

endmodule
